// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch sequencer types and constants
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - issue and stall event counters for the fetch sequencer
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic            stall,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
);

    // Counters survive start; only rst clears them. Both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (issue) perf_fetched <= perf_fetched + 32'd1;
            if (stall) perf_stall   <= perf_stall + 32'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC owner and fetch sequencer; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            busy,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
`endif
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH * 4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic running;
    logic handshake;
    logic slot_free;
    logic pc_bad;
    logic fault_now;
    logic issue;

    assign running   = (state_q == ST_RUN);
    assign handshake = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;
    assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);

    // Priority in RUN: redirect, then halt, then fault check, then issue.
    assign fault_now = running && !redirect_valid && !halt_req && slot_free && pc_bad;
    assign issue     = running && !redirect_valid && !halt_req && slot_free && !pc_bad;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;

        if (handshake) out_valid_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush whatever is pending, even if decode is taking it now.
                    out_valid_d = 1'b0;
                    pc_d        = redirect_target;
                    if (halt_req) state_d = ST_HALT;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (fault_now) begin
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    state_d    = ST_HALT;
                end else if (issue) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    pc_d        = pc_q + PC_STEP;
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    fault_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            fault_q     <= 1'b0;
            fault_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign busy      = running;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = running && out_valid_q && !out_ready;

    fetch_perf_counters u_perf (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .stall        (stall),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard bench for instr_fetch_ctrl (two depths)
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, halt_req, redirect_valid, out_ready;
    logic [31:0] redirect_target, imem_addr, imem_rdata, out_instr, out_pc, fault_pc;
    logic        out_valid, busy, fault;

    logic        rst_b, start_b, ready_b;
    logic [31:0] addr_b, rdata_b, instr_b, pc_b, fault_pc_b;
    logic        valid_b, busy_b, fault_b;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched_b, perf_stall_b;
`endif

    logic [31:0] mem [0:31];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hdead_beef;
    assign rdata_b    = (addr_b < 32'd128) ? mem[addr_b[6:2]] : 32'hdead_beef;

    instr_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_DEPTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .halt_req        (halt_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .busy            (busy),
        .fault           (fault),
        .fault_pc        (fault_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    instr_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_b (
        .clk             (clk),
        .rst             (rst_b),
        .start           (start_b),
        .halt_req        (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .imem_addr       (addr_b),
        .imem_rdata      (rdata_b),
        .out_valid       (valid_b),
        .out_ready       (ready_b),
        .out_instr       (instr_b),
        .out_pc          (pc_b),
        .busy            (busy_b),
        .fault           (fault_b),
        .fault_pc        (fault_pc_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched_b),
        .perf_stall      (perf_stall_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.instr = mem[pc[6:2]];
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h0031_00b3;  // add x1,x2,x3
        mem[1] = 32'h4062_8233;  // sub x4,x5,x6
        mem[2] = 32'h0094_63b3;  // or  x7,x8,x9
        for (int i = 3; i < 32; i++) mem[i] = 32'h1000_0000 | i;

        rst = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; out_ready = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b0;

        // Monitor: a handshake seen at the negedge completes at the next posedge.
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_pc", out_pc, 32'hffff_ffff);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_instr", out_instr, e.instr);
                        chk("sb_pc", out_pc, e.pc);
                    end
                end
            end
        join_none

        repeat (2) tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        rst = 1'b0;

        push(32'h0); push(32'h4); push(32'h8); push(32'h10);

        start = 1'b1; out_ready = 1'b1;
        tick(); start = 1'b0;
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_no_valid_yet", {31'b0, out_valid}, 32'd0);
        tick();
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_pc", out_pc, 32'h0);
        tick();
        chk("second_pc", out_pc, 32'h4);
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_pc", out_pc, 32'h4);
            chk("stall_instr", out_instr, mem[1]);
            chk("stall_imem_addr", imem_addr, 32'h8);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_pc", out_pc, 32'h8);
        chk("resume_instr", out_instr, mem[2]);
        tick();
        chk("pre_redirect_pc", out_pc, 32'hc);
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h10;
        tick(); redirect_valid = 1'b0;
        chk("redirect_flush", {31'b0, out_valid}, 32'd0);
        chk("redirect_addr", imem_addr, 32'h10);
        out_ready = 1'b1;
        tick();
        chk("redirect_target_valid", {31'b0, out_valid}, 32'd1);
        chk("redirect_target_pc", out_pc, 32'h10);
        tick();
        chk("after_target_pc", out_pc, 32'h14);
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h6;
        tick(); redirect_valid = 1'b0;
        chk("misalign_flush", {31'b0, out_valid}, 32'd0);
        chk("misalign_addr", imem_addr, 32'h6);
        tick();
        chk("misalign_fault", {31'b0, fault}, 32'd1);
        chk("misalign_fault_pc", fault_pc, 32'h6);
        chk("misalign_halted", {31'b0, busy}, 32'd0);
        chk("misalign_no_valid", {31'b0, out_valid}, 32'd0);

        start = 1'b1; out_ready = 1'b1;
        tick(); start = 1'b0;
        chk("restart_fault_clear", {31'b0, fault}, 32'd0);
        chk("restart_busy", {31'b0, busy}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        push(32'h0);
        tick();
        chk("restart_pc", out_pc, 32'h0);
        halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        chk("halt_busy", {31'b0, busy}, 32'd0);
        chk("halt_drained", {31'b0, out_valid}, 32'd0);
        chk("halt_no_issue_addr", imem_addr, 32'h4);
        tick();
        chk("sb_drained", exp_q.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        // Issues 0,4,8,C,10,14,0; stalls: 3 at pc 4, 1 at C, 1 at 14.
        chk("perf_fetched", perf_fetched, 32'd7);
        chk("perf_stall", perf_stall, 32'd5);
`endif

        // Small-memory instance: 4 words, pc 0x10 is out of range.
        repeat (2) tick();
        rst_b = 1'b0;
        start_b = 1'b1; ready_b = 1'b1;
        tick(); start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_seq_pc", pc_b, 32'(i * 4));
            chk("b_seq_instr", instr_b, mem[i]);
        end
        tick();
        chk("b_range_fault", {31'b0, fault_b}, 32'd1);
        chk("b_range_fault_pc", fault_pc_b, 32'h10);
        chk("b_range_halted", {31'b0, busy_b}, 32'd0);
        chk("b_range_no_valid", {31'b0, valid_b}, 32'd0);
        start_b = 1'b1;
        tick(); start_b = 1'b0;
        chk("b_restart_fault_clear", {31'b0, fault_b}, 32'd0);
        tick();
        chk("b_restart_pc", pc_b, 32'h0);
        chk("b_restart_valid", {31'b0, valid_b}, 32'd1);
        ready_b = 1'b0;
        tick();
        chk("b_stall_valid", {31'b0, valid_b}, 32'd1);
        rst_b = 1'b1;
        tick(); rst_b = 1'b0;
        chk("b_rst_valid", {31'b0, valid_b}, 32'd0);
        chk("b_rst_instr", instr_b, 32'd0);
        chk("b_rst_pc", pc_b, 32'd0);
        chk("b_rst_busy", {31'b0, busy_b}, 32'd0);
        chk("b_rst_fault", {31'b0, fault_b}, 32'd0);
        chk("b_rst_fault_pc", fault_pc_b, 32'd0);
        chk("b_rst_addr", addr_b, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
